// File: rtl/sonar_uart_tx_if.sv
// sonar_uart_tx_if -- request/status/serial bundle for the sonar UART transmitter.
//   start     : request to send one sonar frame (master -> slave)
//   distance  : 16-bit unsigned range in inches, captured on accept (master -> slave)
//   busy      : frame is being converted or sent (slave -> master)
//   done      : one-cycle pulse marking the end of a frame (slave -> master)
//   tx        : UART serial line, idle high (slave -> master)
interface sonar_uart_tx_if;
  logic        start;
  logic [15:0] distance;
  logic        busy;
  logic        done;
  logic        tx;

  modport master (output start, output distance, input busy, input done, input tx);
  modport slave  (input start, input distance, output busy, output done, output tx);
endinterface

// File: rtl/sonar_uart_tx.sv
// sonar_uart_tx -- sends a sonar range reading as the ASCII frame "R<h><t><u>\r".
//   Distance is saturated to 999, converted to BCD by repeated subtraction,
//   then shifted out as 8N1 (or 8E1) UART bytes with no inter-byte gap.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sonar_uart_tx_if.slave (start, distance, busy, done, tx)
// Parameters:
//   CLK_HZ : clock frequency in Hz
//   BAUD   : serial bit rate; bit period is CLK_HZ/BAUD cycles (truncated)
// Build option:
//   SONAR_UART_TX_PARITY_EN : when defined, an even-parity bit follows data bit 7.
module sonar_uart_tx #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic             clk,
  input  logic             reset,
  sonar_uart_tx_if.slave   bus
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] DIV_M1 = TW'(DIV - 1);

`ifdef SONAR_UART_TX_PARITY_EN
  // Bit index 8 is the parity slot.
  localparam int unsigned BW = 4;
  localparam logic [BW-1:0] LAST_BIT = 4'd8;
`else
  localparam int unsigned BW = 3;
  localparam logic [BW-1:0] LAST_BIT = 3'd7;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    byte_q,  byte_d;
  logic [BW-1:0] bit_q,   bit_d;
  logic [9:0]    rem_q,   rem_d;
  logic [3:0]    hund_q,  hund_d;
  logic [3:0]    tens_q,  tens_d;
  logic          tx_q,    tx_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic          bit_end;
  logic [7:0]    cur_byte;
  logic [BW-1:0] nbit;
  logic          nbit_val;

  assign bit_end = (timer_q == DIV_M1);
  assign nbit    = bit_q + BW'(1);

  // Byte under transmission; units digit is whatever remains after subtraction.
  always_comb begin
    case (byte_q)
      3'd0:    cur_byte = 8'h52;
      3'd1:    cur_byte = {4'h3, hund_q};
      3'd2:    cur_byte = {4'h3, tens_q};
      3'd3:    cur_byte = {4'h3, rem_q[3:0]};
      default: cur_byte = 8'h0D;
    endcase
  end

  always_comb begin
`ifdef SONAR_UART_TX_PARITY_EN
    nbit_val = (nbit == 4'd8) ? ^cur_byte : cur_byte[nbit[2:0]];
`else
    nbit_val = cur_byte[nbit[2:0]];
`endif
  end

  // tx is registered: each branch computes the line level for the next cycle,
  // so the line changes only on clock edges.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    rem_d   = rem_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          rem_d   = (bus.distance > 16'd999) ? 10'd999 : bus.distance[9:0];
          hund_d  = '0;
          tens_d  = '0;
          byte_d  = '0;
          bit_d   = '0;
          timer_d = '0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        tx_d = 1'b1;
        if (rem_q >= 10'd100) begin
          rem_d  = rem_q - 10'd100;
          hund_d = hund_q + 4'd1;
        end else if (rem_q >= 10'd10) begin
          rem_d  = rem_q - 10'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          tx_d    = 1'b0;
          timer_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          timer_d = '0;
          bit_d   = '0;
          tx_d    = cur_byte[0];
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = nbit;
            tx_d  = nbit_val;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (byte_q == 3'd4) begin
            byte_d  = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 3'd1;
            tx_d    = 1'b0;
            state_d = S_START;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      rem_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
